hamming_secded_codec: RTL and testbench

- Parametrised, pipelined Hamming SECDED block. Each transaction is an encode or a decode.
- Encode: builds a codeword from DATA_W data bits, placing parity at power-of-two positions plus an overall parity bit at position 0.
- Decode: corrects any single-bit error, flags double errors, and keeps saturating error counters.
- Sits between register file/memory and datapath as the hardware replacement for software parity routines.

---
 rtl/hamming_pkg.sv | 37 +++
 rtl/hamming_secded_codec_if.sv | 28 ++
 rtl/hamming_syndrome.sv | 17 +
 rtl/hamming_secded_codec.sv | 135 +++++++++++++
 tb/tb_hamming_secded_codec.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, status encoding and codeword-layout helpers for the SECDED codec.
package hamming_pkg;
  localparam logic kENC = 1'b0;
  localparam logic kDEC = 1'b1;

  typedef enum logic [1:0] {
    kOK   = 2'b00,
    kCORR = 2'b01,
    kDBL  = 2'b10
  } status_e;

  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int i);
    return (i != 0) && ((i & (i - 1)) == 0);
  endfunction

  // Codeword position of data bit j: non-power-of-two slots from 3 upward.
  function automatic int data_pos(input int j);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 3; p < 1024; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == j && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction
endpackage

// File: rtl/hamming_secded_codec_if.sv
// Input/output handshake bundle of the SECDED codec.
interface hamming_secded_codec_if #(
  parameter int DATA_W = 11,
  parameter int CODE_W = 16,
  parameter int R      = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [CODE_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic [R-1:0]      out_syndrome;
  logic [1:0]        out_status;

  modport master (
    output in_valid, in_mode, in_word, out_ready,
    input  in_ready, out_valid, out_mode, out_code, out_data, out_syndrome, out_status
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready,
    output in_ready, out_valid, out_mode, out_code, out_data, out_syndrome, out_status
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of a codeword.
module hamming_syndrome #(
  parameter int CODE_W = 16,
  parameter int R      = 4
) (
  input  logic [CODE_W-1:0] word,
  output logic [R-1:0]      syn,
  output logic              par
);
  always_comb begin
    syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (word[i]) syn = syn ^ R'(i);
    end
    par = ^word;
  end
endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage SECDED encode/decode pipeline with valid/ready flow control and
// saturating corrected/uncorrectable event counters.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_codec_if.slave bus,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_dbl
);
  localparam int R      = calc_r(DATA_W);
  localparam int CODE_W = DATA_W + R + 1;
  localparam logic [R:0] kCodeLim = (R + 1)'(CODE_W);

  logic [CODE_W-1:0] placed, s1_in;
  logic [R-1:0]      syn_in;
  logic              par_in;

  logic              s1_valid, s1_mode, s1_par;
  logic [CODE_W-1:0] s1_word;
  logic [R-1:0]      s1_syn;

  logic              s1_load, s2_load;
  logic [CODE_W-1:0] enc_fill, flip, code_n;
  logic [DATA_W-1:0] data_n;
  logic [R-1:0]      syn_n;
  status_e           dec_status, status_n;

  assign s2_load      = !bus.out_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // Parity slots are zero in the encode word so the syndrome directly yields p1..pR.
  for (genvar i = 0; i < CODE_W; i++) begin : g_slot
    if (i == 0) begin : g_p0
      assign placed[i]   = 1'b0;
      assign enc_fill[i] = s1_par ^ (^s1_syn);
    end else if (is_pow2(i)) begin : g_pk
      assign placed[i]   = 1'b0;
      assign enc_fill[i] = s1_syn[$clog2(i)];
    end else begin : g_d
      assign enc_fill[i] = 1'b0;
    end
    assign flip[i] = s1_par && (s1_syn == R'(i));
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    localparam int P = data_pos(j);
    assign placed[P] = bus.in_word[j];
    assign data_n[j] = code_n[P];
  end

  assign s1_in = (bus.in_mode == kENC) ? placed : bus.in_word;

  hamming_syndrome #(.CODE_W(CODE_W), .R(R)) u_syn (
    .word (s1_in),
    .syn  (syn_in),
    .par  (par_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode <= bus.in_mode;
        s1_word <= s1_in;
        s1_syn  <= syn_in;
        s1_par  <= par_in;
      end
    end
  end

  // Any syndrome outside the codeword matches no flip bit, so dbl words pass untouched.
  always_comb begin
    dec_status = kOK;
    if (s1_par) begin
      dec_status = ({1'b0, s1_syn} < kCodeLim) ? kCORR : kDBL;
    end else if (s1_syn != '0) begin
      dec_status = kDBL;
    end
    if (s1_mode == kENC) begin
      code_n   = s1_word | enc_fill;
      syn_n    = '0;
      status_n = kOK;
    end else begin
      code_n   = s1_word ^ flip;
      syn_n    = s1_syn;
      status_n = dec_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.out_mode     <= 1'b0;
      bus.out_code     <= '0;
      bus.out_data     <= '0;
      bus.out_syndrome <= '0;
      bus.out_status   <= '0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_mode     <= s1_mode;
        bus.out_code     <= code_n;
        bus.out_data     <= data_n;
        bus.out_syndrome <= syn_n;
        bus.out_status   <= status_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr <= '0;
      cnt_dbl  <= '0;
    end else if (cnt_clear) begin
      cnt_corr <= '0;
      cnt_dbl  <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (bus.out_status == kCORR && cnt_corr != '1) cnt_corr <= cnt_corr + 1'b1;
      if (bus.out_status == kDBL  && cnt_dbl  != '1) cnt_dbl  <= cnt_dbl + 1'b1;
    end
  end
endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for the SECDED codec: scoreboarded results, stall stability,
// async reset mid-stall and counter saturation/clear on a narrow-counter instance.
module tb_hamming_secded_codec;
  import hamming_pkg::*;

  typedef struct packed {
    logic        mode;
    logic [15:0] code;
    logic [10:0] data;
    logic [3:0]  syn;
    logic [1:0]  status;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clear = 1'b0, cnt_clear2 = 1'b0;
  logic [15:0] cnt_corr, cnt_dbl;
  logic [1:0]  cnt_corr2, cnt_dbl2;

  hamming_secded_codec_if #(.DATA_W(11), .CODE_W(16), .R(4)) bus ();
  hamming_secded_codec_if #(.DATA_W(11), .CODE_W(16), .R(4)) bus2 ();

  hamming_secded_codec #(.DATA_W(11), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clear(cnt_clear),
    .cnt_corr(cnt_corr), .cnt_dbl(cnt_dbl)
  );

  hamming_secded_codec #(.DATA_W(11), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_clear(cnt_clear2),
    .cnt_corr(cnt_corr2), .cnt_dbl(cnt_dbl2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  exp_t sb[$];
  exp_t pend;
  logic accepted = 1'b0;
  logic stalled_prev = 1'b0;
  logic [33:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic m, logic [15:0] c, logic [10:0] d, logic [3:0] s, logic [1:0] st);
    return '{mode: m, code: c, data: d, syn: s, status: st};
  endfunction

  function automatic logic [33:0] out_vec();
    return {bus.out_mode, bus.out_code, bus.out_data, bus.out_syndrome, bus.out_status};
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (stalled_prev) chk("stall_stable", 64'(out_vec()), 64'(snap));
    stalled_prev = bus.out_valid && !bus.out_ready;
    snap = out_vec();
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(bus.out_code), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("out_mode",     64'(bus.out_mode),     64'(e.mode));
        chk("out_code",     64'(bus.out_code),     64'(e.code));
        chk("out_data",     64'(bus.out_data),     64'(e.data));
        chk("out_syndrome", 64'(bus.out_syndrome), 64'(e.syn));
        chk("out_status",   64'(bus.out_status),   64'(e.status));
      end
    end
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) sb.push_back(pend);
    @(posedge clk);
    #1;
    if (accepted) bus.in_valid = 1'b0;
  endtask

  task automatic present(input logic m, input logic [15:0] w, input exp_t e);
    pend = e;
    bus.in_mode = m;
    bus.in_word = w;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 50);
    chk("accept_in_time", 64'(accepted), 64'd1);
  endtask

  task automatic send(input logic m, input logic [15:0] w, input exp_t e);
    present(m, w, e);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic enc_latency(input logic [15:0] w, input logic [15:0] code, input logic [10:0] d);
    send(kENC, w, mk(kENC, code, d, 4'd0, 2'b00));
    chk("lat_not_early", 64'(bus.out_valid), 64'd0);
    tick();
    chk("lat_valid_2", 64'(bus.out_valid), 64'd1);
    drain();
  endtask

  initial begin
    int p0;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_word = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_mode = kDEC; bus2.in_word = 16'h002F; bus2.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_code",  64'(bus.out_code),  64'd0);
    chk("rst_out_status", 64'(bus.out_status), 64'd0);
    chk("rst_cnt_corr",  64'(cnt_corr),      64'd0);
    chk("rst_cnt_dbl",   64'(cnt_dbl),       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    enc_latency(16'h0000, 16'h0000, 11'h000);
    enc_latency(16'h07FF, 16'hFFFF, 11'h7FF);
    enc_latency(16'h0001, 16'h000F, 11'h001);
    enc_latency(16'hF801, 16'h000F, 11'h001);

    send(kDEC, 16'h000F, mk(kDEC, 16'h000F, 11'h001, 4'd0, 2'b00));
    drain();
    chk("cnt_corr_ok", 64'(cnt_corr), 64'd0);
    send(kDEC, 16'h002F, mk(kDEC, 16'h000F, 11'h001, 4'd5, 2'b01));
    drain();
    chk("cnt_corr_1", 64'(cnt_corr), 64'd1);
    send(kDEC, 16'h000E, mk(kDEC, 16'h000F, 11'h001, 4'd0, 2'b01));
    drain();
    chk("cnt_corr_2", 64'(cnt_corr), 64'd2);
    send(kDEC, 16'h006F, mk(kDEC, 16'h006F, 11'h007, 4'd3, 2'b10));
    drain();
    chk("cnt_dbl_1", 64'(cnt_dbl), 64'd1);
    chk("cnt_corr_hold", 64'(cnt_corr), 64'd2);

    // Backpressure: two fill the pipe, the third must wait.
    p0 = pops;
    bus.out_ready = 1'b0;
    send(kENC, 16'h0001, mk(kENC, 16'h000F, 11'h001, 4'd0, 2'b00));
    send(kDEC, 16'h002F, mk(kDEC, 16'h000F, 11'h001, 4'd5, 2'b01));
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    present(kENC, 16'h07FF, mk(kENC, 16'hFFFF, 11'h7FF, 4'd0, 2'b00));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_not_accepted", 64'(accepted), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    wait_accept();
    send(kDEC, 16'h006F, mk(kDEC, 16'h006F, 11'h007, 4'd3, 2'b10));
    drain();
    chk("bp_count", 64'(pops - p0), 64'd4);
    chk("bp_cnt_corr", 64'(cnt_corr), 64'd3);
    chk("bp_cnt_dbl", 64'(cnt_dbl), 64'd2);

    // Async reset with both stages full and output stalled.
    bus.out_ready = 1'b0;
    send(kENC, 16'h0001, mk(kENC, 16'h000F, 11'h001, 4'd0, 2'b00));
    send(kDEC, 16'h002F, mk(kDEC, 16'h000F, 11'h001, 4'd5, 2'b01));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_code",  64'(bus.out_code),  64'd0);
    chk("arst_cnt_corr",  64'(cnt_corr),      64'd0);
    chk("arst_cnt_dbl",   64'(cnt_dbl),       64'd0);
    sb.delete();
    stalled_prev = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    enc_latency(16'h0001, 16'h000F, 11'h001);

    // Narrow counter: saturation at 3, then clear beats a same-cycle increment.
    bus2.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("sat_cnt_corr", 64'(cnt_corr2), 64'd3);
    chk("sat_cnt_dbl",  64'(cnt_dbl2),  64'd0);
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_out_valid", 64'(bus2.out_valid), 64'd1);
    chk("clr_out_status", 64'(bus2.out_status), 64'd1);
    cnt_clear2 = 1'b1;
    @(posedge clk); #1;
    cnt_clear2 = 1'b0;
    chk("clr_wins", 64'(cnt_corr2), 64'd0);
    chk("clr_consumed", 64'(bus2.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
